// File: rtl/i2c_reg_sequencer.sv
// I2C master that writes a table of {sub_addr, data} words to one device at init,
// then accepts single-register runtime writes. Contains its own quarter-bit engine and NACK retry.
module i2c_reg_sequencer #(
  parameter int         CLK_FREQ    = 200_000_000,
  parameter int         I2C_FREQ    = 20_000,
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         NUM_REGS    = 11,
  parameter int         MAX_RETRIES = 3,
  parameter int         GAP_BITS    = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  tbl_index,
  input  logic [15:0] tbl_data,
  input  logic        wr_req,
  input  logic [15:0] wr_data,
  output logic        wr_ack,
  output logic        busy,
  output logic        init_done,
  output logic        error,
  output logic [7:0]  nack_count,
  output logic        i2c_sclk,
  inout  wire         i2c_sdat
);

  localparam int QDIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
  localparam int DW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam int GAP_Q    = (GAP_BITS > 0) ? GAP_BITS * 4 : 1;
  localparam int GW       = (GAP_Q > 1) ? $clog2(GAP_Q) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, ACK, STOP, GAP} state_e;

  state_e      state, stateNext;
  logic [DW-1:0] divCnt;
  logic        qtick;
  logic [1:0]  qCnt;
  logic [2:0]  bitCnt;
  logic [1:0]  byteCnt;
  logic [GW-1:0] gapCnt;
  logic [23:0] shiftReg;
  logic [15:0] rtWord;
  logic [15:0] loadWord;
  logic        srcInit;
  logic        frameFail;
  logic [3:0]  retryCnt;
  logic [7:0]  tblIndex;
  logic [7:0]  nackCnt;
  logic        initDone;
  logic        errorReg;
  logic        wrAck;
  logic [1:0]  sdaSync;
  logic        sclReg, sdaLowReg;
  logic        sclNext, sdaLowNext;
  logic        initPending, quarterEnd, loadNow, ackSample, gapEnd;

  assign qtick       = (divCnt == DW'(QDIV - 1));
  assign initPending = !initDone && !errorReg;
  assign quarterEnd  = qtick && (qCnt == 2'd3);
  assign loadNow     = (state == LOAD) && qtick;
  assign ackSample   = (state == ACK) && qtick && (qCnt == 2'd2);
  assign gapEnd      = (state == GAP) && qtick && (gapCnt == GW'(GAP_Q - 1));
  // A runtime retry resends the word captured on the first attempt, not the live wr_data.
  assign loadWord    = initPending ? tbl_data : ((retryCnt != 4'd0) ? rtWord : wr_data);

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      divCnt  <= '0;
      state   <= IDLE;
      sdaSync <= 2'b11;
    end else begin
      divCnt  <= qtick ? '0 : divCnt + DW'(1);
      state   <= stateNext;
      sdaSync <= {sdaSync[0], i2c_sdat};
    end
  end

  // NOTE: stateNext gets a default first so no path through the case can infer a latch.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (initPending || (wr_req && !wrAck)) stateNext = LOAD;
      LOAD:  if (qtick) stateNext = START;
      START: if (quarterEnd) stateNext = DATA;
      DATA:  if (quarterEnd && bitCnt == 3'd7) stateNext = ACK;
      ACK:   if (quarterEnd) stateNext = (frameFail || byteCnt == 2'd2) ? STOP : DATA;
      STOP:  if (quarterEnd) stateNext = GAP;
      GAP:   if (gapEnd) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      qCnt      <= '0;
      bitCnt    <= '0;
      byteCnt   <= '0;
      gapCnt    <= '0;
      shiftReg  <= '0;
      rtWord    <= '0;
      srcInit   <= 1'b0;
      frameFail <= 1'b0;
      retryCnt  <= '0;
      tblIndex  <= '0;
      nackCnt   <= '0;
      initDone  <= 1'b0;
      errorReg  <= 1'b0;
      wrAck     <= 1'b0;
    end else begin
      wrAck <= 1'b0;
      if (state == IDLE || state == LOAD) qCnt <= '0;
      else if (qtick)                     qCnt <= qCnt + 2'd1;

      if (loadNow) begin
        shiftReg  <= {DEV_ADDR, 1'b0, loadWord};
        srcInit   <= initPending;
        frameFail <= 1'b0;
        bitCnt    <= '0;
        byteCnt   <= '0;
        if (!initPending && retryCnt == 4'd0) rtWord <= wr_data;
      end

      if (state == DATA && quarterEnd) begin
        shiftReg <= {shiftReg[22:0], 1'b0};
        bitCnt   <= bitCnt + 3'd1;
      end

      if (ackSample && sdaSync[1]) begin
        frameFail <= 1'b1;
        if (nackCnt != 8'hFF) nackCnt <= nackCnt + 8'd1;
      end
      if (state == ACK && quarterEnd) byteCnt <= byteCnt + 2'd1;

      if (state == STOP && quarterEnd) gapCnt <= '0;
      else if (state == GAP && qtick)  gapCnt <= gapCnt + GW'(1);

      if (gapEnd) begin
        if (!frameFail) begin
          retryCnt <= '0;
          if (srcInit) begin
            if (tblIndex == 8'(NUM_REGS - 1)) initDone <= 1'b1;
            tblIndex <= tblIndex + 8'd1;
          end else begin
            wrAck <= 1'b1;
          end
        end else if (retryCnt < 4'(MAX_RETRIES)) begin
          retryCnt <= retryCnt + 4'd1;
        end else begin
          retryCnt <= '0;
          errorReg <= 1'b1;
          if (!srcInit) wrAck <= 1'b1;
        end
      end
    end
  end

  // Bus levels per quarter; registered so SCL/SDA are glitch-free.
  always_comb begin
    sclNext    = 1'b1;
    sdaLowNext = 1'b0;
    unique case (state)
      START: begin
        sclNext    = (qCnt != 2'd3);
        sdaLowNext = (qCnt != 2'd0);
      end
      DATA: begin
        sclNext    = (qCnt == 2'd1) || (qCnt == 2'd2);
        sdaLowNext = !shiftReg[23];
      end
      ACK:  sclNext = (qCnt == 2'd1) || (qCnt == 2'd2);
      STOP: begin
        sclNext    = (qCnt != 2'd0);
        sdaLowNext = (qCnt == 2'd0) || (qCnt == 2'd1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclReg    <= 1'b1;
      sdaLowReg <= 1'b0;
    end else begin
      sclReg    <= sclNext;
      sdaLowReg <= sdaLowNext;
    end
  end

  assign i2c_sdat   = sdaLowReg ? 1'b0 : 1'bz;
  assign i2c_sclk   = sclReg;
  assign tbl_index  = tblIndex;
  assign wr_ack     = wrAck;
  assign busy       = (state != IDLE);
  assign init_done  = initDone;
  assign error      = errorReg;
  assign nack_count = nackCnt;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Scoreboard bench: a bus-level slave decodes frames and a monitor compares them
// against queued expectations; a second monitor checks wr_ack pulses.
module tb_i2c_reg_sequencer;

  typedef struct {
    int          n;
    logic [23:0] v;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tbl_index;
  logic [15:0] tbl_data;
  logic        wr_req = 1'b0;
  logic [15:0] wr_data = 16'h0;
  logic        wr_ack, busy, init_done, error;
  logic [7:0]  nack_count;
  logic        i2c_sclk;
  wire         sda;
  logic        slaveLow = 1'b0;

  pullup (sda);
  assign sda = slaveLow ? 1'b0 : 1'bz;

  logic [15:0] tbl [0:2];
  initial begin
    tbl[0] = 16'h1E00;
    tbl[1] = 16'h0812;
    tbl[2] = 16'h1201;
  end
  assign tbl_data = (tbl_index < 8'd3) ? tbl[tbl_index[1:0]] : 16'h0000;

  i2c_reg_sequencer #(
    .CLK_FREQ(8000), .I2C_FREQ(1000), .DEV_ADDR(7'h1A),
    .NUM_REGS(3), .MAX_RETRIES(2), .GAP_BITS(1)
  ) dut (
    .clk(clk), .rst(rst), .tbl_index(tbl_index), .tbl_data(tbl_data),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy),
    .init_done(init_done), .error(error), .nack_count(nack_count),
    .i2c_sclk(i2c_sclk), .i2c_sdat(sda)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mode = 0;          // 0: always ACK, 1: NACK byte 1 of first frame, 2: never ACK
  frame_t expQ[$];
  int ackQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic slaveNacks(input int startNo, input int byteIdx);
    if (mode == 2) return 1'b1;
    if (mode == 1) return (startNo == 1) && (byteIdx == 1);
    return 1'b0;
  endfunction

  // Bus slave and frame monitor
  logic        prevScl = 1'b1, prevSda = 1'b1;
  logic        inFrame = 1'b0, ackPhase = 1'b0;
  int          bitIdx = 0, nb = 0, startCnt = 0;
  logic [7:0]  cur = 8'h0;
  logic [23:0] fv = 24'h0;

  always @(negedge clk) begin
    logic sclNow, sdaNow;
    frame_t e;
    if (rst) begin
      inFrame = 1'b0; ackPhase = 1'b0; bitIdx = 0; nb = 0; fv = '0;
      slaveLow = 1'b0; startCnt = 0; prevScl = 1'b1; prevSda = 1'b1;
    end else begin
      sclNow = i2c_sclk;
      sdaNow = sda;
      if (prevScl && sclNow && prevSda && !sdaNow) begin
        inFrame = 1'b1; ackPhase = 1'b0; bitIdx = 0; nb = 0; fv = '0;
        startCnt++;
      end else if (prevScl && sclNow && !prevSda && sdaNow) begin
        if (inFrame) begin
          if (expQ.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got %0d bytes %06h expected none", nb, fv);
          end else begin
            e = expQ.pop_front();
            check("frame_len", nb, e.n);
            check("frame_bytes", {8'h0, fv}, {8'h0, e.v});
          end
        end
        inFrame = 1'b0;
      end else if (inFrame && !prevScl && sclNow) begin
        if (bitIdx < 8) begin
          cur = {cur[6:0], sdaNow};
          bitIdx++;
        end
      end else if (inFrame && prevScl && !sclNow) begin
        if (ackPhase) begin
          slaveLow = 1'b0; ackPhase = 1'b0; bitIdx = 0;
        end else if (bitIdx == 8) begin
          fv = {fv[15:0], cur};
          slaveLow = !slaveNacks(startCnt, nb);
          nb++;
          ackPhase = 1'b1;
        end
      end
      prevScl = sclNow;
      prevSda = sdaNow;
    end
  end

  // wr_ack monitor
  logic prevAck = 1'b0, prevBusy = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (prevAck) check("wr_ack_width", wr_ack, 1'b0);
      if (wr_ack) begin
        if (ackQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wr_ack: got pulse expected none at %0t", $time);
        end else begin
          void'(ackQ.pop_front());
          check("wr_ack_init_done", init_done, 1'b1);
          check("wr_ack_after_gap", {prevBusy, busy}, 2'b10);
          check("wr_ack_frame_done", expQ.size(), 0);
        end
      end
    end
    prevAck  = wr_ack;
    prevBusy = busy;
  end

  task automatic push_frame(input int n, input logic [23:0] v);
    frame_t f;
    f.n = n;
    f.v = v;
    expQ.push_back(f);
  endtask

  task automatic push_init3();
    push_frame(3, 24'h341E00);
    push_frame(3, 24'h340812);
    push_frame(3, 24'h341201);
  endtask

  task automatic do_reset(input int m);
    @(negedge clk);
    rst = 1'b1;
    mode = m;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_init_done(input string name);
    for (int i = 0; i < 2000 && !init_done; i++) @(negedge clk);
    check(name, init_done, 1'b1);
  endtask

  initial begin
    int lat;
    // Reset values held for 3 cycles
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tbl_index", tbl_index, 8'd0);
    check("rst_wr_ack", wr_ack, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_nack_count", nack_count, 8'd0);
    check("rst_scl", i2c_sclk, 1'b1);
    check("rst_sda", sda, 1'b1);

    // Init sequence, all ACKed
    push_init3();
    rst = 1'b0;
    lat = 0;
    while (lat < 8 && !(i2c_sclk && !sda)) begin
      @(negedge clk);
      lat++;
    end
    check("start_latency", {31'h0, (i2c_sclk && !sda)}, 32'h1);
    wait_init_done("init_done_timeout");
    check("init_tbl_index", tbl_index, 8'd3);
    check("init_error", error, 1'b0);
    check("init_nack", nack_count, 8'd0);
    check("init_idle", busy, 1'b0);
    repeat (50) @(negedge clk);
    check("init_drained", expQ.size(), 0);

    // Single NACK on byte 1 of frame 0
    do_reset(1);
    push_frame(2, 24'h00341E);
    push_init3();
    rst = 1'b0;
    wait_init_done("nack1_done_timeout");
    check("nack1_count", nack_count, 8'd1);
    check("nack1_error", error, 1'b0);
    check("nack1_tbl_index", tbl_index, 8'd3);
    repeat (50) @(negedge clk);
    check("nack1_drained", expQ.size(), 0);

    // Persistent NACK: MAX_RETRIES=2 gives three attempts
    do_reset(2);
    for (int i = 0; i < 3; i++) push_frame(1, 24'h000034);
    rst = 1'b0;
    for (int i = 0; i < 2000 && !error; i++) @(negedge clk);
    check("pnack_error", error, 1'b1);
    check("pnack_init_done", init_done, 1'b0);
    check("pnack_count", nack_count, 8'd3);
    check("pnack_tbl_index", tbl_index, 8'd0);
    repeat (400) @(negedge clk);
    check("pnack_idle_busy", busy, 1'b0);
    check("pnack_idle_scl", i2c_sclk, 1'b1);
    check("pnack_idle_sda", sda, 1'b1);
    check("pnack_drained", expQ.size(), 0);

    // Runtime write requested during init frame 1
    do_reset(0);
    push_init3();
    push_frame(3, 24'h3404F0);
    rst = 1'b0;
    for (int i = 0; i < 1000 && !(tbl_index == 8'd1 && busy); i++) @(negedge clk);
    check("rt_frame1_seen", {tbl_index, 7'h0, busy}, {8'd1, 7'h0, 1'b1});
    wr_data = 16'h04F0;
    wr_req  = 1'b1;
    ackQ.push_back(1);
    for (int i = 0; i < 2000 && !wr_ack; i++) @(negedge clk);
    check("rt_wr_ack_seen", wr_ack, 1'b1);
    wr_req  = 1'b0;
    wr_data = 16'hFFFF;
    repeat (300) @(negedge clk);
    check("rt_drained", expQ.size(), 0);
    check("rt_ack_drained", ackQ.size(), 0);
    check("rt_idle", busy, 1'b0);

    // Reset during a DATA quarter with SCL high and SDA low
    do_reset(0);
    rst = 1'b0;
    for (int i = 0; i < 500 && !(inFrame && bitIdx == 1 && i2c_sclk && !sda); i++) @(negedge clk);
    check("mid_cond", {29'h0, inFrame, i2c_sclk, sda}, 32'h6);
    rst = 1'b1;
    @(negedge clk);
    check("mid_scl", i2c_sclk, 1'b1);
    check("mid_sda", sda, 1'b1);
    check("mid_busy", busy, 1'b0);
    push_init3();
    rst = 1'b0;
    wait_init_done("mid_restart_timeout");
    check("mid_tbl_index", tbl_index, 8'd3);
    repeat (50) @(negedge clk);
    check("mid_drained", expQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_reg_sequencer.md
Name: i2c_reg_sequencer

Overview:
- Parametrised I2C master that writes a configurable-length table of 16-bit register words to one 7-bit device, followed by runtime single-register writes.
- Includes its own open-drain bit engine, NACK retry and error reporting; no separate I2C controller is needed.
- Sits between the system clock domain and an external codec or peripheral. It replaces fixed-length, fixed-address codec setup logic.
- The register table lives outside the block (a LUT or ROM addressed by tbl_index), so one instance serves any codec.

Parameters:
- CLK_FREQ, 200000000, system clock frequency in Hz
- I2C_FREQ, 20000, SCL frequency in Hz
- DEV_ADDR, 7'h1A, 7-bit slave address; R/W bit is always 0
- NUM_REGS, 11, number of table entries written at init (1..255)
- MAX_RETRIES, 3, re-attempts per frame after a NACK (0..15)
- GAP_BITS, 1, idle bit-times between frames

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tbl_index  out  8  table address of the current init entry
- tbl_data  in  16  table word {sub_addr[7:0], data[7:0]}, combinational from tbl_index
- wr_req  in  1  runtime write request; held until wr_ack
- wr_data  in  16  runtime word, same format as tbl_data
- wr_ack  out  1  one-cycle pulse when the runtime frame completes, ACKed or failed
- busy  out  1  a frame is in progress
- init_done  out  1  sticky; all NUM_REGS entries written with ACK
- error  out  1  sticky; a frame exhausted its retries
- nack_count  out  8  saturating count of NACKs seen
- i2c_sclk  out  1  SCL, push-pull
- i2c_sdat  inout  1  SDA, open-drain: drives 0 or Z, never 1

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - tbl_index=0, wr_ack=0, busy=0, init_done=0, error=0, nack_count=0
  - i2c_sclk=1, SDA released (Z)
  - divider, state and retry counter cleared
- Reset mid-frame aborts the frame immediately. SCL and SDA are high/released on the cycle after rst is sampled. No STOP is generated.
- Tick generator:
  - QDIV = CLK_FREQ/(4*I2C_FREQ), computed at elaboration.
  - The counter runs 0..QDIV-1 and pulses qtick for one clk on wrap.
  - All bus activity advances only on qtick.
- Frame format: START, 3 bytes MSB first, STOP.
  - Bytes are {DEV_ADDR,1'b0}, word[15:8], word[7:0].
  - Each byte is followed by an ACK slot.
- Bit slot is 4 quarters:
  - q0: SCL=0, set SDA
  - q1: SCL=1
  - q2: SCL=1, sample SDA (ACK slots only)
  - q3: SCL=0
- START is 4 quarters: SDA=Z/SCL=1, SDA=0/SCL=1, SDA=0/SCL=1, SDA=0/SCL=0.
- STOP is 4 quarters: SDA=0/SCL=0, SDA=0/SCL=1, SDA=Z/SCL=1, SDA=Z/SCL=1.
- ACK slot: SDA released by the master. ACK means SDA sampled 0 at q2; 1 is a NACK.
- A NACK on any byte:
  - finishes that byte's ACK slot, then issues STOP;
  - increments nack_count (saturates at 255);
  - marks the frame failed.
- States: IDLE, LOAD, START, DATA, ACK, STOP, GAP, with transitions:
  - IDLE→LOAD: when the init sequence is incomplete and error=0 (init has priority), or when wr_req=1.
  - LOAD: latches the 24-bit shift word and the frame source (init/runtime). Sets busy=1.
  - START→DATA→ACK repeats 3 times, then STOP.
  - STOP→GAP. GAP lasts GAP_BITS×4 qticks.
  - GAP→IDLE.
- Frame outcome, decided at end of GAP:
  - Success, init source: tbl_index increments. When tbl_index reaches NUM_REGS, init_done=1 and tbl_index holds at NUM_REGS.
  - Success, runtime source: wr_ack pulses.
  - Failure with retry count < MAX_RETRIES: retry count increments and the same word is re-sent. tbl_data is re-read in LOAD.
  - Failure with retries exhausted: error=1. An init sequence halts (init_done stays 0); a runtime frame pulses wr_ack. Retry count clears.
- The retry count also clears on every success.
- Runtime writes are accepted only in IDLE when init is complete or halted.
  - wr_req asserted during init is held off; no wr_ack until its own frame completes.
  - wr_data is latched in LOAD only; later changes are ignored until the next request.
- busy is 1 from LOAD through end of GAP.
- One frame = 4 + 3×36 + 4 + GAP_BITS×4 quarters = 120 qticks at GAP_BITS=1.

Test Plan:
- Reset, CLK_FREQ=8000, I2C_FREQ=1000 (QDIV=2): hold rst 3 cycles → all outputs at reset values, SDA=Z, SCL=1. First START begins within 2 qticks of release.
- Init sequence: NUM_REGS=3, table {1E00, 0812, 1201}, slave always ACKs → 3 frames on the bus:
  - bytes 34,1E,00 / 34,08,12 / 34,12,01;
  - init_done=1 after the third GAP;
  - tbl_index=3, error=0, nack_count=0.
- Single NACK: slave NACKs the 2nd byte of frame 0 once → STOP after that ACK slot, frame 0 re-sent intact, nack_count=1, init completes normally.
- Persistent NACK, MAX_RETRIES=2: slave never ACKs → exactly 3 attempts of frame 0, then error=1, init_done=0, nack_count=3, bus idle, no further frames.
- Runtime write during init: wr_req with wr_data=0x04F0 asserted during frame 1 → no wr_ack until init_done. The next frame is 34,04,F0, and wr_ack pulses one cycle after its GAP.
- Reset mid-frame: rst asserted during a DATA quarter with SCL=1, SDA=0 → next cycle SCL=1, SDA=Z, busy=0. After release, init restarts from tbl_index=0.
